load_unit: RTL
==============

LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 Parameter MEM_LATENCY, default 1: cycles from mem_rd assertion to valid mem_rdata; legal range 1..15.
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  load request pulse; sampled only in IDLE.
REQ-005 addr  input  32  byte address of the load.
REQ-006 lscontrol  input  2  size: 0 lw, 1 lh, 2 lb, 3 treated as lw.
REQ-007 mem_rdata  input  32  word read from memory.
REQ-008 mem_addr  output  32  word-aligned address {addr_q[31:2],2'b00}.
REQ-009 mem_rd  output  1  memory read strobe.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 err  output  1  misaligned-access flag, valid while done=1.
REQ-013 mdr_out  output  32  raw captured memory word (memory data register).
REQ-014 load_data  output  32  lane-aligned, zero-extended load result.

Function
REQ-015 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-016 IDLE with start=1: latch addr and lscontrol into addr_q/ctl_q, go to REQ; start=0 stays IDLE.
REQ-017 REQ: mem_rd=1 for exactly one cycle, mem_addr driven from addr_q; go to WAIT with counter cleared.
REQ-018 WAIT: counter increments each cycle; on the cycle counter equals MEM_LATENCY-1, capture mem_rdata into mdr_out and go to DONE.
REQ-019 DONE: done=1 for one cycle, then IDLE.
REQ-020 Start-to-done latency SHALL be MEM_LATENCY+2 cycles (start sampled cycle 0, done in cycle MEM_LATENCY+2).
REQ-021 load_data, updated with mdr_out: lw -> word; lh -> {16'd0, halfword selected by addr_q[1]}; lb -> {24'd0, byte selected by addr_q[1:0]}; little-endian lanes (lane 0 = bits 7:0).
REQ-022 start while busy=1 SHALL be ignored and not queued.
REQ-023 start asserted in the DONE cycle SHALL be ignored; a new load is accepted from IDLE on the following cycle.
REQ-024 mem_addr SHALL be held stable from REQ through DONE.
REQ-025 mdr_out and load_data SHALL hold their last value until the next successful capture.

Reset
REQ-026 reset=1 at any clock edge, including mid-load, SHALL force IDLE, clear the counter, and drive mem_rd=0, done=0, err=0, busy=0.
REQ-027 reset SHALL clear mdr_out, load_data, addr_q, ctl_q to 0; mem_addr reads 0.
REQ-028 reset SHALL take priority over start in the same cycle.

Configuration
REQ-029 Macro LOAD_MISALIGN_EXC_EN defined: at start, lh with addr[0]=1 or lw/ctl 3 with addr[1:0]!=0 goes IDLE->DONE directly, no mem_rd, err=1 with done, mdr_out/load_data unchanged; latency 1 cycle.
REQ-030 Macro LOAD_MISALIGN_EXC_EN undefined: err tied 0; misaligned lw ignores addr[1:0]; misaligned lh uses addr[1] only; full memory sequence always runs.

Verification
REQ-031 MEM_LATENCY=1, lw addr=0x100, mem_rdata=0xDEADBEEF -> mem_rd in cycle 1, mem_addr=0x100, done cycle 3, load_data=0xDEADBEEF.
REQ-032 lb addr=0x103, mem_rdata=0x80AA55CC -> load_data=0x00000080, mdr_out=0x80AA55CC; lh addr=0x102 -> 0x000080AA.
REQ-033 MEM_LATENCY=4, lw -> done exactly 6 cycles after start; second start pulses during busy produce no extra mem_rd.
REQ-034 Reset asserted in WAIT -> next cycle busy=0, mem_rd=0, load_data=0; no done pulse follows.
REQ-035 LOAD_MISALIGN_EXC_EN defined, lh addr=0x101 -> done and err=1 in cycle 1, mem_rd never asserted; undefined -> normal load, load_data={16'd0, mem_rdata[15:0]}, err=0.

Source files
------------

// File: rtl/load_unit.sv
// -----------------------------------------------------------------------------
// load_unit
//
// Single-outstanding load sequencer. A start pulse in IDLE latches the byte
// address and access size, issues one memory read strobe, waits MEM_LATENCY
// cycles for the read word, then captures it into the memory data register
// (mdr_out) together with a lane-aligned, zero-extended result (load_data)
// and raises done for one cycle.
//
// Parameters
//   MEM_LATENCY  cycles from mem_rd assertion to valid mem_rdata (1..15)
//
// Ports
//   clk        in   1   system clock, rising edge
//   reset      in   1   synchronous, active-high reset
//   start      in   1   load request pulse, honoured only in IDLE
//   addr       in   32  byte address of the load
//   lscontrol  in   2   access size: 0 lw, 1 lh, 2 lb, 3 lw
//   mem_rdata  in   32  word returned by memory
//   mem_addr   out  32  word-aligned read address
//   mem_rd     out  1   one-cycle memory read strobe
//   busy       out  1   high whenever the unit is not idle
//   done       out  1   one-cycle completion pulse
//   err        out  1   misaligned-access flag, meaningful while done=1
//   mdr_out    out  32  raw captured memory word
//   load_data  out  32  lane-aligned, zero-extended load result
//
// Build option
//   LOAD_MISALIGN_EXC_EN  when defined, a misaligned lh/lw completes at once
//                         with err=1 and no memory access. When undefined,
//                         err is tied low and the low address bits that do
//                         not select a lane are simply ignored.
// -----------------------------------------------------------------------------
module load_unit #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [1:0]  lscontrol,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] mdr_out,
  output logic [31:0] load_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Access sizes; code 3 behaves as a word load.
  localparam logic [1:0] CTL_LH = 2'd1;
  localparam logic [1:0] CTL_LB = 2'd2;

  // Final WAIT count: the read word is valid on this cycle.
  localparam logic [3:0] LAST_CNT = 4'(MEM_LATENCY - 1);

  state_t      state;
  state_t      next_state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [1:0]  ctl_q;
  logic        capture;
  logic        misalign;
  logic [31:0] lane_data;

  // ---------------------------------------------------------------------------
  // Misalignment detection on the incoming request
  // ---------------------------------------------------------------------------
`ifdef LOAD_MISALIGN_EXC_EN
  logic err_q;

  always_comb begin
    misalign = 1'b0;
    unique case (lscontrol)
      CTL_LH:  misalign = addr[0];
      CTL_LB:  misalign = 1'b0;
      default: misalign = (addr[1:0] != 2'b00);
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          next_state = misalign ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        next_state = S_WAIT;
      end
      S_WAIT: begin
        if (cnt == LAST_CNT) begin
          capture    = 1'b1;
          next_state = S_DONE;
        end
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Lane extraction from the returned word, using the latched address/size.
  // Lanes are little-endian: lane 0 is bits 7:0.
  // ---------------------------------------------------------------------------
  always_comb begin
    lane_data = mem_rdata;
    unique case (ctl_q)
      CTL_LH: begin
        lane_data = addr_q[1] ? {16'd0, mem_rdata[31:16]}
                              : {16'd0, mem_rdata[15:0]};
      end
      CTL_LB: begin
        unique case (addr_q[1:0])
          2'd0:    lane_data = {24'd0, mem_rdata[7:0]};
          2'd1:    lane_data = {24'd0, mem_rdata[15:8]};
          2'd2:    lane_data = {24'd0, mem_rdata[23:16]};
          default: lane_data = {24'd0, mem_rdata[31:24]};
        endcase
      end
      default: begin
        lane_data = mem_rdata;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, request latch, latency counter and data registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the data registers are cleared too, so mdr_out/load_data read
      // zero after reset rather than whatever the last load left behind.
      state     <= S_IDLE;
      cnt       <= 4'd0;
      addr_q    <= 32'd0;
      ctl_q     <= 2'd0;
      mdr_out   <= 32'd0;
      load_data <= 32'd0;
`ifdef LOAD_MISALIGN_EXC_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state <= next_state;

      // Request is captured only on acceptance; starts while busy are dropped.
      if (state == S_IDLE && start) begin
        addr_q <= addr;
        ctl_q  <= lscontrol;
`ifdef LOAD_MISALIGN_EXC_EN
        err_q  <= misalign;
`endif
      end

      if (state == S_REQ) begin
        cnt <= 4'd0;
      end else if (state == S_WAIT) begin
        cnt <= cnt + 4'd1;
      end

      // Both data outputs move together and only on a real memory return.
      if (capture) begin
        mdr_out   <= mem_rdata;
        load_data <= lane_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // addr_q only changes in IDLE, so mem_addr is stable from REQ through DONE.
  assign mem_addr = {addr_q[31:2], 2'b00};
  assign mem_rd   = (state == S_REQ);
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

`ifdef LOAD_MISALIGN_EXC_EN
  assign err = done & err_q;
`else
  assign err = 1'b0;
`endif

endmodule
